m_unit_ctrl: RTL and testbench



---
 rtl/m_pkg.sv | 56 +++++
 rtl/m_unit_ctrl_abs.sv | 11 +
 rtl/m_unit_ctrl.sv | 156 +++++++++++++++
 tb/tb_m_unit_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/m_pkg.sv
// Shared types for the M-extension sequencer: op and state encodings,
// the latched request record, and the ALU mux-select encodings that
// normally come from m_definitions.svh (guarded so that header can win).
`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH   1
`define MUX_MULTA_U        1'b0
`define MUX_MULTA_S        1'b1
`endif
`ifndef MUX_MULTB_LENGTH
`define MUX_MULTB_LENGTH   1
`define MUX_MULTB_U        1'b0
`define MUX_MULTB_S        1'b1
`endif
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`define MUX_DIV_REM_R      1'b0
`define MUX_DIV_REM_Z      1'b1
`endif

package m_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } m_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } m_state_e;

    localparam int M_DIV_ITERS = 32;

    // Request fields kept for the whole operation
    typedef struct packed {
        m_op_e op;
        logic  neg1;
        logic  neg2;
        logic  rs2_nz;
    } m_req_t;

    // funct3[2] separates the divide/remainder group from the multiplies
    function automatic logic is_div(input m_op_e o);
        logic [2:0] v;
        v = o;
        return v[2];
    endfunction
endpackage

// File: rtl/m_unit_ctrl_abs.sv
// m_abs_sign: magnitude and sign flag of a 32-bit operand. With is_signed
// low the value passes through unchanged and is reported non-negative.
module m_abs_sign (
    input  logic [31:0] val,
    input  logic        is_signed,
    output logic [31:0] mag,
    output logic        neg
);
    assign neg = is_signed & val[31];
    assign mag = neg ? (~val + 32'd1) : val;
endmodule

// File: rtl/m_unit_ctrl.sv
// m_unit_ctrl: sequencer for the m_alu datapath. One RV32M op at a time;
// multiplies take one ALU pass, divides/remainders run 32 restoring
// shift-subtract iterations followed by a sign-fix step.
// Optional macro M_DIV_FASTPATH_EN: divide by zero, signed overflow and
// |rs1| < |rs2| skip the iterations and jump straight to FIX.
import m_pkg::*;

module m_unit_ctrl (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     op,
    input  logic [31:0]                    rs1,
    input  logic [31:0]                    rs2,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    result,
    output logic                           busy,
    output logic [`MUX_MULTA_LENGTH-1:0]   mux_multA,
    output logic [`MUX_MULTB_LENGTH-1:0]   mux_multB,
    output logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
    output logic [31:0]                    R,
    output logic [62:0]                    D,
    output logic [31:0]                    Z,
    input  logic [31:0]                    sub_result,
    input  logic [31:0]                    div_rem,
    input  logic [31:0]                    div_rem_neg,
    input  logic [63:0]                    product
);
    m_state_e    state, state_nx;
    m_req_t      req;
    m_op_e       op_in;
    logic [4:0]  cnt;
    logic        fix_phase;
    logic        accept, div_signed, step_sub, pick_neg, fp_hit;
    logic [31:0] mag1, mag2;
    logic        neg1, neg2;

    assign op_in      = m_op_e'(op);
    assign div_signed = (op_in == OP_DIV) || (op_in == OP_REM);
    assign accept     = (state == S_IDLE) && in_valid && !flush;
    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DONE);

    // Subtract only while the shifted divisor fits in 32 bits and R covers it
    assign step_sub = (D[62:32] == 31'd0) && (R >= D[31:0]);

    assign pick_neg = (req.op == OP_DIV) ? (req.neg1 ^ req.neg2) & req.rs2_nz :
                      (req.op == OP_REM) ? req.neg1 : 1'b0;

    m_abs_sign u_abs1 (.val(rs1), .is_signed(div_signed), .mag(mag1), .neg(neg1));
    m_abs_sign u_abs2 (.val(rs2), .is_signed(div_signed), .mag(mag2), .neg(neg2));

`ifdef M_DIV_FASTPATH_EN
    logic div_ovf;
    assign div_ovf = div_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign fp_hit  = (rs2 == 32'd0) || div_ovf || (mag1 < mag2);
`else
    assign fp_hit  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next state and ALU mux selects; flush overrides everything outside IDLE
    always_comb begin
        state_nx    = state;
        mux_multA   = `MUX_MULTA_U;
        mux_multB   = `MUX_MULTB_U;
        mux_div_rem = `MUX_DIV_REM_R;
        case (state)
            S_IDLE: if (accept) state_nx = is_div(op_in) ? (fp_hit ? S_FIX : S_DIV) : S_MUL;
            S_MUL: begin
                if (req.op == OP_MULH || req.op == OP_MULHSU) mux_multA = `MUX_MULTA_S;
                if (req.op == OP_MULH)                        mux_multB = `MUX_MULTB_S;
                state_nx = S_DONE;
            end
            S_DIV: if (cnt == 5'd0) state_nx = S_FIX;
            S_FIX: begin
                if (req.op == OP_DIV || req.op == OP_DIVU) mux_div_rem = `MUX_DIV_REM_Z;
                if (fix_phase) state_nx = S_DONE;
            end
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush && state != S_IDLE) state_nx = S_IDLE;
    end

    // Operand load, divide iterations and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            R         <= '0;
            D         <= '0;
            Z         <= '0;
            cnt       <= '0;
            req       <= '0;
            fix_phase <= 1'b0;
            result    <= '0;
        end else if (flush && state != S_IDLE) begin
            fix_phase <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    req       <= '{op: op_in, neg1: neg1, neg2: neg2, rs2_nz: |rs2};
                    fix_phase <= 1'b0;
                    if (is_div(op_in)) begin
                        D   <= {mag2, 31'd0};
                        cnt <= 5'(M_DIV_ITERS - 1);
`ifdef M_DIV_FASTPATH_EN
                        if (rs2 == 32'd0) begin
                            R <= mag1;
                            Z <= '1;
                        end else if (div_ovf) begin
                            R <= '0;
                            Z <= 32'h8000_0000;
                        end else begin
                            R <= mag1;
                            Z <= '0;
                        end
`else
                        R <= mag1;
                        Z <= '0;
`endif
                    end else begin
                        R <= rs1;
                        D <= {rs2, 31'd0};
                    end
                end
                S_MUL: result <= (req.op == OP_MUL) ? product[31:0] : product[63:32];
                S_DIV: begin
                    if (step_sub) begin
                        R <= sub_result;
                        Z <= {Z[30:0], 1'b1};
                    end else begin
                        Z <= {Z[30:0], 1'b0};
                    end
                    D <= D >> 1;
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                // First FIX cycle holds mux_div_rem steady so the ALU negate
                // path settles; the second captures the signed answer.
                S_FIX: begin
                    if (!fix_phase) fix_phase <= 1'b1;
                    else            result <= pick_neg ? div_rem_neg : div_rem;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_m_unit_ctrl.sv
// Directed bench for m_unit_ctrl with a behavioural m_alu stand-in.
import m_pkg::*;

module tb_m_unit_ctrl;
    logic                           clk = 1'b0;
    logic                           reset, in_valid, flush, out_ready;
    logic                           in_ready, out_valid, busy;
    logic [2:0]                     op;
    logic [31:0]                    rs1, rs2, result, R, Z;
    logic [62:0]                    D;
    logic [`MUX_MULTA_LENGTH-1:0]   mux_multA;
    logic [`MUX_MULTB_LENGTH-1:0]   mux_multB;
    logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
    logic [31:0]                    sub_result, div_rem, div_rem_neg;
    logic [63:0]                    product;
    logic [63:0]                    alu_a, alu_b;

    int total = 0;
    int bad   = 0;

`ifdef M_DIV_FASTPATH_EN
    localparam int FL = 2;
`else
    localparam int FL = 34;
`endif

    always #5 clk = ~clk;

    m_unit_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy),
        .mux_multA(mux_multA), .mux_multB(mux_multB), .mux_div_rem(mux_div_rem),
        .R(R), .D(D), .Z(Z),
        .sub_result(sub_result), .div_rem(div_rem), .div_rem_neg(div_rem_neg),
        .product(product)
    );

    // m_alu stand-in
    always_comb begin
        alu_a       = (mux_multA == `MUX_MULTA_S) ? {{32{R[31]}}, R} : {32'd0, R};
        alu_b       = (mux_multB == `MUX_MULTB_S) ? {{32{D[62]}}, D[62:31]} : {32'd0, D[62:31]};
        product     = alu_a * alu_b;
        sub_result  = R - D[31:0];
        div_rem     = (mux_div_rem == `MUX_DIV_REM_Z) ? Z : R;
        div_rem_neg = -div_rem;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Issue one op, measure latency, optionally hold out_ready low, then hand off
    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int elat,
                         input int hold);
        int lat;
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(elat));
        chk({nm, "_res"}, {32'd0, result}, {32'd0, exp});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, "_hold"}, {61'd0, out_valid, in_ready, busy}, {61'd0, 3'b101});
            chk({nm, "_hold_res"}, {32'd0, result}, {32'd0, exp});
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_idle"}, {62'd0, in_ready, out_valid}, {62'd0, 2'b10});
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_flags"}, {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
        chk({nm, "_result"}, {32'd0, result}, 64'd0);
        chk({nm, "_R"}, {32'd0, R}, 64'd0);
        chk({nm, "_D"}, {1'b0, D}, 64'd0);
        chk({nm, "_Z"}, {32'd0, Z}, 64'd0);
        chk({nm, "_mux"}, 64'({mux_multA, mux_multB, mux_div_rem}), 64'd0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 3'd0; rs1 = '0; rs2 = '0;

        vecs.push_back('{3'(OP_MUL),    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1});
        vecs.push_back('{3'(OP_MULHU),  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 1});
        vecs.push_back('{3'(OP_MULH),   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'(OP_MULHSU), 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'(OP_DIV),    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{3'(OP_REM),    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{3'(OP_DIVU),   32'd100,       32'd0,         32'hFFFF_FFFF, FL});
        vecs.push_back('{3'(OP_REMU),   32'd100,       32'd0,         32'd100,       FL});
        vecs.push_back('{3'(OP_DIV),    32'd5,         32'd0,         32'hFFFF_FFFF, FL});
        vecs.push_back('{3'(OP_DIV),    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FL});
        vecs.push_back('{3'(OP_REM),    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         FL});
        vecs.push_back('{3'(OP_DIVU),   32'd1000,      32'd7,         32'd142,       34});
        vecs.push_back('{3'(OP_REMU),   32'd1000,      32'd7,         32'd6,         34});
        vecs.push_back('{3'(OP_DIV),    32'd3,         32'hFFFF_FFF6, 32'd0,         FL});
        vecs.push_back('{3'(OP_REM),    32'd3,         32'hFFFF_FFF6, 32'd3,         FL});
        vecs.push_back('{3'(OP_REM),    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 34});

        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1 chk_reset_vals("rst");

        // flush while IDLE blocks acceptance
        @(negedge clk); in_valid = 1'b1; flush = 1'b1; op = 3'(OP_MUL); rs1 = 32'd3; rs2 = 32'd4;
        @(posedge clk); #1;
        chk("idle_flush_busy", {63'd0, busy}, 64'd0);
        in_valid = 1'b0; flush = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].lat, 0);

        // DIVU 1000/7 aborted by flush at cycle 10
        @(negedge clk); op = 3'(OP_DIVU); rs1 = 32'd1000; rs2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_state", {61'd0, in_ready, busy, out_valid}, {61'd0, 3'b100});
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("flush_no_valid", {63'd0, seen}, 64'd0);

        // next request after flush, with consumer stalled for 5 cycles
        do_op("mul_after_flush", 3'(OP_MUL), 32'd3, 32'd4, 32'd12, 1, 5);

        // reset during divide iteration 20
        @(negedge clk); op = 3'(OP_DIVU); rs1 = 32'd1000; rs2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("mid_div_busy", {63'd0, busy}, 64'd1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        @(negedge clk); reset = 1'b0;

        do_op("post_rst_mul", 3'(OP_MUL), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
